// File: rtl/sevenseg_scan_array.sv
// N-digit multiplexed seven-segment driver: digit register file, prescaled scan, registered outputs.
// Optional SEG_BRIGHTNESS_EN adds a 3-bit brightness input that shortens each digit's on-time.
module sevenseg_scan_array #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1024,
  parameter int unsigned COMMON_ANODE = 0,
  localparam int unsigned AW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [5:0]            wr_data,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [2:0]            brightness,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_tick
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] CntMax = PW'(PRESCALE - 1);
  localparam logic [AW-1:0] IdxMax = AW'(NUM_DIGITS - 1);
  localparam logic [AW:0]   NumDig = (AW+1)'(NUM_DIGITS);
  localparam logic          Inv    = (COMMON_ANODE != 0);

  logic [PW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [5:0]            digits_q [NUM_DIGITS];
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  ft_q, ft_d;
  logic                  wrap;
  logic                  wr_ok;
  logic                  slot_on;
  logic [5:0]            cur;
  logic [6:0]            seg_raw;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign wr_ok = wr_en && ({1'b0, wr_addr} < NumDig);

`ifdef SEG_BRIGHTNESS_EN
  logic [2:0]  bright_q;
  logic [31:0] lim;

  // Brightness is latched in the dead cycle so a slot never changes length midway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bright_q <= 3'd0;
    end else if (ena && cnt_q == '0) begin
      bright_q <= brightness;
    end
  end

  always_comb begin
    lim     = ((32'(bright_q) + 32'd1) * PRESCALE) >> 3;
    slot_on = (cnt_q != '0) && (32'(cnt_q) < lim);
  end
`else
  assign slot_on = (cnt_q != '0);
`endif

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    wrap  = 1'b0;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      if (idx_q == IdxMax) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur     = digits_q[idx_q];
    seg_raw = cur[5] ? 7'h00 : decode(cur[3:0]);
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    sel_d   = '0;
    ft_d    = 1'b0;
    if (ena) begin
      seg_d = seg_raw;
      dp_d  = cur[4] & ~cur[5];
      if (slot_on) sel_d[idx_q] = 1'b1;
      ft_d  = wrap;
    end
    seg_d = seg_d ^ {7{Inv}};
    dp_d  = dp_d ^ Inv;
    sel_d = sel_d ^ {NUM_DIGITS{Inv}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) digits_q[i] <= 6'b100000;
      seg_q <= {7{Inv}};
      dp_q  <= Inv;
      sel_q <= {NUM_DIGITS{Inv}};
      ft_q  <= 1'b0;
    end else begin
      if (ena) begin
        cnt_q <= cnt_d;
        idx_q <= idx_d;
      end
      if (wr_ok) digits_q[wr_addr] <= wr_data;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      sel_q <= sel_d;
      ft_q  <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = sel_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_sevenseg_scan_array.sv
// Randomised scoreboard bench: two configurations share stimulus; a time-based model predicts outputs.
module tb_sevenseg_scan_array;

  logic       clk = 1'b0;
  logic       rst_n, ena, wr_en;
  logic [2:0] wa;
  logic [5:0] wr_data;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1, ft0, ft1;
  logic [3:0] sel0;
  logic [5:0] sel1;

  always #5 clk = ~clk;

  sevenseg_scan_array #(.NUM_DIGITS(4), .PRESCALE(4), .COMMON_ANODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wa[1:0]),
    .wr_data(wr_data),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(3'd7),
`endif
    .seg(seg0), .dp(dp0), .dig_sel(sel0), .frame_tick(ft0)
  );

  sevenseg_scan_array #(.NUM_DIGITS(6), .PRESCALE(5), .COMMON_ANODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wa),
    .wr_data(wr_data),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(3'd7),
`endif
    .seg(seg1), .dp(dp1), .dig_sel(sel1), .frame_tick(ft1)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: enabled cycles since reset, and digit contents, per configuration.
  int         t_m [2];
  logic [5:0] dig_m [2][8];

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  bit done   = 1'b0;

  task automatic model_step(input int i, input int n, input int p, input bit ca,
                            input bit rst, input bit en, input bit we, input int addr,
                            input logic [5:0] data, output logic [16:0] e);
    logic [6:0] s;
    logic       d_p, f;
    logic [7:0] sl, selm;
    logic [5:0] d;
    int idx, ph;
    s = '0; d_p = 1'b0; f = 1'b0; sl = '0;
    selm = 8'((1 << n) - 1);
    if (!rst) begin
      t_m[i] = 0;
      for (int k = 0; k < 8; k++) dig_m[i][k] = 6'h20;
    end else begin
      if (en) begin
        idx = (t_m[i] / p) % n;
        ph  = t_m[i] % p;
        d   = dig_m[i][idx];
        s   = d[5] ? 7'h00 : seg_tab[d[3:0]];
        d_p = d[4] & ~d[5];
        sl  = (ph != 0) ? 8'(1 << idx) : 8'h00;
        f   = (ph == p - 1) && (idx == n - 1);
        t_m[i]++;
      end
      if (we && addr < n) dig_m[i][addr] = data;
    end
    if (ca) begin
      s = ~s; d_p = ~d_p; sl = ~sl & selm;
    end
    e = {f, d_p, s, sl};
  endtask

  // Monitor: every cycle the DUTs present a new output word.
  initial begin
    logic [16:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        want = q0.pop_front();
        got  = {ft0, dp0, seg0, 4'b0000, sel0};
        checks++;
        if (got === want) passes++;
        else $display("FAIL dut0 cycle %0d: got %h required %h", cyc, got, want);
      end
      if (q1.size() > 0) begin
        want = q1.pop_front();
        got  = {ft1, dp1, seg1, 2'b00, sel1};
        checks++;
        if (got === want) passes++;
        else $display("FAIL dut1 cycle %0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  end

  initial begin
    logic [16:0] e0, e1;
    int off_len = 0;
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wa = '0; wr_data = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c < 3) begin
        rst_n = 1'b0; ena = 1'b1; wr_en = ($urandom % 2) == 0;
      end else if (c < 60) begin
        rst_n = 1'b1; ena = 1'b1; wr_en = (c > 40) && (($urandom % 3) == 0);
      end else begin
        rst_n = ($urandom % 300) != 0;
        if (off_len == 0 && ($urandom % 40) == 0) off_len = $urandom_range(1, 12);
        ena = (off_len == 0);
        if (off_len > 0) off_len--;
        wr_en = ($urandom % 4) == 0;
      end
      wa      = 3'($urandom % 8);
      wr_data = 6'($urandom);
      model_step(0, 4, 4, 1'b0, rst_n, ena, wr_en, int'(wa[1:0]), wr_data, e0);
      model_step(1, 6, 5, 1'b1, rst_n, ena, wr_en, int'(wa), wr_data, e1);
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) @(negedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d entries pending required 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
